game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 153 +++++++++++++++
 tb/tb_game_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer
// Top-level game flow controller for the video game. Walks the game through
// IDLE -> PLAY -> CRASH -> PLAY ... -> OVER, keeps the score (frames survived)
// and the remaining lives, and builds the control word for the video game
// controller.
//
// Ports:
//   clock           - system clock (25 MHz pixel clock), rising edge only
//   rst             - asynchronous active-low reset
//   frame_tick      - one-cycle pulse per video frame
//   start_btn       - debounced start button level
//   left_btn        - debounced left button level
//   right_btn       - debounced right button level
//   icon_sel        - player icon choice, captured at game start
//   collison_detect - sticky collision flag from the video game controller
//   game_info_reg   - control word: [7] game over, [6:5] icon, [4] fast level,
//                     [3:2] reserved (0), [1:0] steering (10 left, 01 right)
//   score           - frames survived in the current game (saturating)
//   lives           - remaining lives
//   state           - FSM state: IDLE=00, PLAY=01, CRASH=10, OVER=11
module game_sequencer #(
    parameter logic [15:0] LEVEL_UP_SCORE = 16'd600,
    parameter logic [7:0]  CRASH_FRAMES   = 8'd120,
    parameter logic [1:0]  MAX_LIVES      = 2'd3
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic        left_btn,
    input  logic        right_btn,
    input  logic [1:0]  icon_sel,
    input  logic        collison_detect,
    output logic [7:0]  game_info_reg,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        CRASH = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t      cur_state;
    logic [7:0]  crash_count;
    logic        start_prev;
    logic        collide_prev;
    logic        prev_valid;
    logic        start_edge;
    logic        collide_edge;
    logic [1:0]  steer;
    logic [15:0] score_inc;
    logic [15:0] score_next;

    // prev_valid stays low for the first sample after reset, so a start
    // button that is already held when reset releases is treated as an old
    // level rather than a fresh press.
    assign start_edge   = prev_valid & start_btn & ~start_prev;
    assign collide_edge = collison_detect & ~collide_prev;

    // Exactly one button pressed steers; both or neither means straight.
    assign steer = (left_btn & ~right_btn) ? 2'b10 :
                   (right_btn & ~left_btn) ? 2'b01 : 2'b00;

    assign score_inc  = (score == 16'hFFFF) ? score : score + 16'd1;

    // A collision takes priority over a frame tick in the same cycle.
    assign score_next = (cur_state == PLAY && !collide_edge && frame_tick) ?
                        score_inc : score;

    assign state = cur_state;

    // Single registered FSM. Steering bits and the game-over bit default to
    // zero each cycle and are re-asserted only by the branches that land in
    // PLAY or OVER, so every output reflects the state being entered.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cur_state     <= IDLE;
            game_info_reg <= 8'h00;
            score         <= 16'd0;
            lives         <= 2'd0;
            crash_count   <= 8'd0;
            start_prev    <= 1'b0;
            collide_prev  <= 1'b0;
            prev_valid    <= 1'b0;
        end else begin
            start_prev         <= start_btn;
            collide_prev       <= collison_detect;
            prev_valid         <= 1'b1;
            game_info_reg[1:0] <= 2'b00;
            game_info_reg[3:2] <= 2'b00;
            game_info_reg[7]   <= 1'b0;

            case (cur_state)
                IDLE: begin
                    if (start_edge) begin
                        cur_state          <= PLAY;
                        score              <= 16'd0;
                        lives              <= MAX_LIVES;
                        game_info_reg[4]   <= 1'b0;
                        game_info_reg[6:5] <= icon_sel;
                        game_info_reg[1:0] <= steer;
                    end
                end

                PLAY: begin
                    score <= score_next;
                    if (score_next >= LEVEL_UP_SCORE) begin
                        game_info_reg[4] <= 1'b1;
                    end
                    if (collide_edge) begin
                        lives <= lives - 2'd1;
                        if (lives == 2'd1) begin
                            cur_state        <= OVER;
                            game_info_reg[7] <= 1'b1;
                        end else begin
                            cur_state   <= CRASH;
                            crash_count <= 8'd0;
                        end
                    end else begin
                        game_info_reg[1:0] <= steer;
                    end
                end

                CRASH: begin
                    if (frame_tick) begin
                        if (crash_count == CRASH_FRAMES - 8'd1) begin
                            cur_state          <= PLAY;
                            crash_count        <= 8'd0;
                            game_info_reg[1:0] <= steer;
                        end else begin
                            crash_count <= crash_count + 8'd1;
                        end
                    end
                end

                OVER: begin
                    if (start_edge) begin
                        cur_state <= IDLE;
                    end else begin
                        game_info_reg[7] <= 1'b1;
                    end
                end

                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer
// Self-checking bench for game_sequencer. Directed scenarios check the
// documented behaviours against fixed values; a randomized run compares every
// cycle against a behavioural model of the game rules.
module tb_game_sequencer;

    localparam int LEVEL_UP  = 600;
    localparam int CRASH_LEN = 120;
    localparam int LIVES_MAX = 3;
    localparam int ST_IDLE   = 0;
    localparam int ST_PLAY   = 1;
    localparam int ST_CRASH  = 2;
    localparam int ST_OVER   = 3;

    logic        clock;
    logic        rst;
    logic        frame_tick;
    logic        start_btn;
    logic        left_btn;
    logic        right_btn;
    logic [1:0]  icon_sel;
    logic        collison_detect;
    logic [7:0]  game_info_reg;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model of the game rules
    int         m_state;
    int         m_score;
    int         m_lives;
    int         m_crash_ticks;
    logic       m_level;
    logic [1:0] m_icon;
    logic [1:0] m_dir;
    logic       m_start_prev;
    logic       m_coll_prev;

    game_sequencer dut (
        .clock           (clock),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .start_btn       (start_btn),
        .left_btn        (left_btn),
        .right_btn       (right_btn),
        .icon_sel        (icon_sel),
        .collison_detect (collison_detect),
        .game_info_reg   (game_info_reg),
        .score           (score),
        .lives           (lives),
        .state           (state)
    );

    // Free-running 100 MHz-style bench clock; period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard time limit so a stuck run still reports.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // A button already held when reset releases counts as "seen high", so
    // the model starts with the previous start level marked as high.
    task automatic model_reset();
        m_state       = ST_IDLE;
        m_score       = 0;
        m_lives       = 0;
        m_crash_ticks = 0;
        m_level       = 1'b0;
        m_icon        = 2'b00;
        m_dir         = 2'b00;
        m_start_prev  = 1'b1;
        m_coll_prev   = 1'b0;
    endtask

    task automatic model_step();
        logic s_edge;
        logic c_edge;
        int   prev_state;
        s_edge       = start_btn && !m_start_prev;
        c_edge       = collison_detect && !m_coll_prev;
        m_start_prev = start_btn;
        m_coll_prev  = collison_detect;
        prev_state   = m_state;
        case (m_state)
            ST_IDLE: if (s_edge) begin
                m_state = ST_PLAY;
                m_score = 0;
                m_lives = LIVES_MAX;
                m_level = 1'b0;
                m_icon  = icon_sel;
            end
            ST_PLAY: begin
                if (c_edge) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = ST_OVER;
                    else begin
                        m_state       = ST_CRASH;
                        m_crash_ticks = 0;
                    end
                end else if (frame_tick && m_score < 65535) begin
                    m_score = m_score + 1;
                end
            end
            ST_CRASH: if (frame_tick) begin
                m_crash_ticks = m_crash_ticks + 1;
                if (m_crash_ticks == CRASH_LEN) m_state = ST_PLAY;
            end
            default: if (s_edge) m_state = ST_IDLE;
        endcase
        if (prev_state == ST_PLAY && m_score >= LEVEL_UP) m_level = 1'b1;
        if (m_state == ST_PLAY && left_btn && !right_btn)      m_dir = 2'b10;
        else if (m_state == ST_PLAY && right_btn && !left_btn) m_dir = 2'b01;
        else                                                   m_dir = 2'b00;
    endtask

    function automatic logic [27:0] model_vec();
        logic [7:0] gir;
        gir = {(m_state == ST_OVER), m_icon, m_level, 2'b00, m_dir};
        return {2'(m_state), 2'(m_lives), 16'(m_score), gir};
    endfunction

    // Drives one cycle of inputs away from the edge, then samples 1 time unit
    // after the rising edge.
    task automatic drive_cycle(input logic s, input logic l, input logic r,
                               input logic c, input logic t, input logic [1:0] ic);
        start_btn       = s;
        left_btn        = l;
        right_btn       = r;
        collison_detect = c;
        frame_tick      = t;
        icon_sel        = ic;
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        start_btn = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
        collison_detect = 1'b0; frame_tick = 1'b0; icon_sel = 2'b00;
        rst = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        start_btn = 1'b0; left_btn = 1'b0; right_btn = 1'b0;
        collison_detect = 1'b0; frame_tick = 1'b0; icon_sel = 2'b00;
        rst = 1'b0;
        model_reset();
        #3;
        n_cmp++; if (state !== 2'b00) begin n_err++; $display("[TB] FAIL reset_state: got %b expected 00", state); end
        n_cmp++; if (score !== 16'd0) begin n_err++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
        n_cmp++; if (lives !== 2'd0) begin n_err++; $display("[TB] FAIL reset_lives: got %0d expected 0", lives); end
        n_cmp++; if (game_info_reg !== 8'h00) begin n_err++; $display("[TB] FAIL reset_gir: got %h expected 00", game_info_reg); end
        @(posedge clock);
        #1;
        rst = 1'b1;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (state !== 2'b00 || game_info_reg !== 8'h00) begin n_err++; $display("[TB] FAIL idle_hold: got state %b gir %h expected 00/00", state, game_info_reg); end
    endtask

    task automatic test_start();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
        n_cmp++; if (state !== 2'b01) begin n_err++; $display("[TB] FAIL start_state: got %b expected 01", state); end
        n_cmp++; if (lives !== 2'd3) begin n_err++; $display("[TB] FAIL start_lives: got %0d expected 3", lives); end
        n_cmp++; if (score !== 16'd0) begin n_err++; $display("[TB] FAIL start_score: got %0d expected 0", score); end
        n_cmp++; if (game_info_reg !== 8'h40) begin n_err++; $display("[TB] FAIL start_gir: got %h expected 40", game_info_reg); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_level_up();
        for (int i = 0; i < LEVEL_UP - 1; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (score !== 16'd599 || game_info_reg[4] !== 1'b0) begin n_err++; $display("[TB] FAIL pre_level: got score %0d lvl %b expected 599/0", score, game_info_reg[4]); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (score !== 16'd600) begin n_err++; $display("[TB] FAIL level_score: got %0d expected 600", score); end
        n_cmp++; if (game_info_reg[4] !== 1'b1) begin n_err++; $display("[TB] FAIL level_bit: got %b expected 1", game_info_reg[4]); end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        n_cmp++; if (game_info_reg[1:0] !== 2'b10) begin n_err++; $display("[TB] FAIL steer_left: got %b expected 10", game_info_reg[1:0]); end
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        n_cmp++; if (game_info_reg[1:0] !== 2'b00) begin n_err++; $display("[TB] FAIL steer_both: got %b expected 00", game_info_reg[1:0]); end
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        n_cmp++; if (game_info_reg !== 8'h51) begin n_err++; $display("[TB] FAIL steer_right: got %h expected 51", game_info_reg); end
        n_cmp++; if (state !== 2'b01 || score !== 16'd600) begin n_err++; $display("[TB] FAIL start_in_play: got state %b score %0d expected 01/600", state, score); end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_crash();
        logic odd;
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        n_cmp++; if (state !== 2'b10) begin n_err++; $display("[TB] FAIL crash_state: got %b expected 10", state); end
        n_cmp++; if (lives !== 2'd2) begin n_err++; $display("[TB] FAIL crash_lives: got %0d expected 2", lives); end
        n_cmp++; if (score !== 16'd600) begin n_err++; $display("[TB] FAIL crash_score: got %0d expected 600", score); end
        n_cmp++; if (game_info_reg[1:0] !== 2'b00) begin n_err++; $display("[TB] FAIL crash_steer: got %b expected 00", game_info_reg[1:0]); end
        // Collision and start edges during CRASH must be ignored.
        for (int i = 1; i < CRASH_LEN; i++) begin
            odd = (i % 2) == 1;
            drive_cycle(odd, 1'b1, 1'b0, odd, 1'b1, 2'b00);
        end
        n_cmp++; if (state !== 2'b10 || lives !== 2'd2 || score !== 16'd600) begin n_err++; $display("[TB] FAIL crash_hold: got state %b lives %0d score %0d expected 10/2/600", state, lives, score); end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (state !== 2'b01 || game_info_reg[1:0] !== 2'b10) begin n_err++; $display("[TB] FAIL crash_exit: got state %b steer %b expected 01/10", state, game_info_reg[1:0]); end
    endtask

    task automatic test_game_over();
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        n_cmp++; if (state !== 2'b10 || lives !== 2'd1) begin n_err++; $display("[TB] FAIL second_crash: got state %b lives %0d expected 10/1", state, lives); end
        for (int i = 0; i < CRASH_LEN; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (state !== 2'b01) begin n_err++; $display("[TB] FAIL second_exit: got %b expected 01", state); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        n_cmp++; if (state !== 2'b11 || lives !== 2'd0) begin n_err++; $display("[TB] FAIL over_state: got state %b lives %0d expected 11/0", state, lives); end
        n_cmp++; if (game_info_reg !== 8'hD0) begin n_err++; $display("[TB] FAIL over_gir: got %h expected d0", game_info_reg); end
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (score !== 16'd600 || lives !== 2'd0 || game_info_reg !== 8'hD0) begin n_err++; $display("[TB] FAIL over_hold: got score %0d lives %0d gir %h expected 600/0/d0", score, lives, game_info_reg); end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        n_cmp++; if (state !== 2'b00 || game_info_reg[7] !== 1'b0) begin n_err++; $display("[TB] FAIL over_exit: got state %b over %b expected 00/0", state, game_info_reg[7]); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_start_with_tick();
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        n_cmp++; if (state !== 2'b01 || score !== 16'd0 || lives !== 2'd3) begin n_err++; $display("[TB] FAIL start_tick: got state %b score %0d lives %0d expected 01/0/3", state, score, lives); end
        n_cmp++; if (game_info_reg !== 8'h20) begin n_err++; $display("[TB] FAIL start_tick_gir: got %h expected 20", game_info_reg); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_reset_mid_crash();
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (state !== 2'b10 || score !== 16'd10) begin n_err++; $display("[TB] FAIL pre_abort: got state %b score %0d expected 10/10", state, score); end
        start_btn = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (state !== 2'b00) begin n_err++; $display("[TB] FAIL abort_state: got %b expected 00", state); end
        n_cmp++; if (score !== 16'd0 || lives !== 2'd0) begin n_err++; $display("[TB] FAIL abort_counts: got score %0d lives %0d expected 0/0", score, lives); end
        n_cmp++; if (game_info_reg !== 8'h00) begin n_err++; $display("[TB] FAIL abort_gir: got %h expected 00", game_info_reg); end
        model_reset();
        @(posedge clock);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
        n_cmp++; if (state !== 2'b00) begin n_err++; $display("[TB] FAIL held_start: got %b expected 00", state); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        n_cmp++; if (state !== 2'b01 || lives !== 2'd3 || game_info_reg !== 8'h60) begin n_err++; $display("[TB] FAIL fresh_start: got state %b lives %0d gir %h expected 01/3/60", state, lives, game_info_reg); end
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 65534; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
        n_cmp++; if (score !== 16'hFFFE || game_info_reg[4] !== 1'b1) begin n_err++; $display("[TB] FAIL sat_pre: got score %h lvl %b expected fffe/1", score, game_info_reg[4]); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00);
            n_cmp++; if (score !== 16'hFFFF) begin n_err++; $display("[TB] FAIL sat_tick%0d: got %h expected ffff", i, score); end
        end
    endtask

    task automatic test_random();
        logic [27:0] exp_vec;
        logic        s, l, r, c, t;
        logic [1:0]  ic;
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            s  = ($urandom_range(0, 7) == 0);
            c  = ($urandom_range(0, 15) == 0);
            t  = 1'($urandom_range(0, 1));
            l  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            ic = 2'($urandom_range(0, 3));
            drive_cycle(s, l, r, c, t, ic);
            exp_vec = model_vec();
            n_cmp++;
            if ({state, lives, score, game_info_reg} !== exp_vec) begin
                n_err++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, {state, lives, score, game_info_reg}, exp_vec);
            end
        end
    endtask

    // Scenario sequence; each scenario continues from where the last left off.
    initial begin
        test_reset();
        test_start();
        test_level_up();
        test_crash();
        test_game_over();
        test_start_with_tick();
        test_reset_mid_crash();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
